// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one single-port memory between an instruction bus and a
//               data bus. One transaction in flight, with a one-cycle ready
//               pulse per completion and an optional ISSUE-phase timeout.
//               Define ARB_RR_EN for round-robin arbitration. Otherwise dbus
//               has fixed priority over ibus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_ibus_req,
    input  logic              I_ibus_we,
    input  logic [ADDR_W-1:0] I_ibus_addr,
    input  logic [DATA_W-1:0] I_ibus_data,
    input  logic [MASK_W-1:0] I_ibus_mask,
    output logic [DATA_W-1:0] O_ibus_data,
    output logic              O_ibus_ready,
    input  logic              I_dbus_req,
    input  logic              I_dbus_we,
    input  logic [ADDR_W-1:0] I_dbus_addr,
    input  logic [DATA_W-1:0] I_dbus_data,
    input  logic [MASK_W-1:0] I_dbus_mask,
    output logic [DATA_W-1:0] O_dbus_data,
    output logic              O_dbus_ready,
    output logic              O_mem_req,
    output logic              O_mem_we,
    output logic [ADDR_W-1:0] O_mem_addr,
    output logic [DATA_W-1:0] O_mem_data,
    output logic [MASK_W-1:0] O_mem_mask,
    input  logic [DATA_W-1:0] I_mem_data,
    input  logic              I_mem_ready,
    output logic              O_bus_err,
    output logic [1:0]        O_grant
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam int                c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [DATA_W-1:0] c_ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    state_t              r_state_q,      w_state_d;
    logic [c_CNT_W-1:0]  r_cnt_q,        w_cnt_d;
    logic [1:0]          r_grant_q,      w_grant_d;
    logic                r_mem_req_q,    w_mem_req_d;
    logic                r_mem_we_q,     w_mem_we_d;
    logic [ADDR_W-1:0]   r_mem_addr_q,   w_mem_addr_d;
    logic [DATA_W-1:0]   r_mem_data_q,   w_mem_data_d;
    logic [MASK_W-1:0]   r_mem_mask_q,   w_mem_mask_d;
    logic [DATA_W-1:0]   r_ibus_data_q,  w_ibus_data_d;
    logic                r_ibus_ready_q, w_ibus_ready_d;
    logic [DATA_W-1:0]   r_dbus_data_q,  w_dbus_data_d;
    logic                r_dbus_ready_q, w_dbus_ready_d;
    logic                r_bus_err_q,    w_bus_err_d;

    logic                w_pick_dbus;
    logic                w_resp_en;
    logic [DATA_W-1:0]   w_resp_data;

`ifdef ARB_RR_EN
    // Pointer remembers the last bus granted; reset value means "dbus last".
    logic r_last_dbus_q, w_last_dbus_d;

    always_comb begin
        w_pick_dbus   = I_dbus_req && (!I_ibus_req || !r_last_dbus_q);
        w_last_dbus_d = r_last_dbus_q;
        if (r_state_q == ST_IDLE && (I_ibus_req || I_dbus_req)) begin
            w_last_dbus_d = w_pick_dbus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_dbus_q <= 1'b1;
        end else begin
            r_last_dbus_q <= w_last_dbus_d;
        end
    end
`else
    assign w_pick_dbus = I_dbus_req;
`endif

    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_grant_d      = r_grant_q;
        w_mem_req_d    = r_mem_req_q;
        w_mem_we_d     = r_mem_we_q;
        w_mem_addr_d   = r_mem_addr_q;
        w_mem_data_d   = r_mem_data_q;
        w_mem_mask_d   = r_mem_mask_q;
        w_ibus_data_d  = r_ibus_data_q;
        w_dbus_data_d  = r_dbus_data_q;
        w_ibus_ready_d = 1'b0;
        w_dbus_ready_d = 1'b0;
        w_bus_err_d    = 1'b0;
        w_resp_en      = 1'b0;
        w_resp_data    = I_mem_data;

        case (r_state_q)
            ST_IDLE: begin
                w_cnt_d = '0;
                if (I_ibus_req || I_dbus_req) begin
                    w_state_d    = ST_ISSUE;
                    w_mem_req_d  = 1'b1;
                    w_grant_d    = w_pick_dbus ? 2'b10 : 2'b01;
                    w_mem_we_d   = w_pick_dbus ? I_dbus_we   : I_ibus_we;
                    w_mem_addr_d = w_pick_dbus ? I_dbus_addr : I_ibus_addr;
                    w_mem_data_d = w_pick_dbus ? I_dbus_data : I_ibus_data;
                    w_mem_mask_d = w_pick_dbus ? I_dbus_mask : I_ibus_mask;
                end
            end
            ST_ISSUE: begin
                w_cnt_d = r_cnt_q + c_CNT_W'(1);
                if (I_mem_ready) begin
                    w_resp_en = 1'b1;
                end else if ((TIMEOUT != 0) && (r_cnt_q == c_TO_LAST)) begin
                    w_resp_en   = 1'b1;
                    w_resp_data = c_ERR_DATA;
                    w_bus_err_d = 1'b1;
                end
                // Ready and data are registered so they appear in RESP.
                if (w_resp_en) begin
                    w_state_d      = ST_RESP;
                    w_mem_req_d    = 1'b0;
                    w_ibus_ready_d = r_grant_q[0];
                    w_dbus_ready_d = r_grant_q[1];
                    if (r_grant_q[0]) w_ibus_data_d = w_resp_data;
                    if (r_grant_q[1]) w_dbus_data_d = w_resp_data;
                end
            end
            ST_RESP: begin
                w_state_d = ST_IDLE;
                w_grant_d = 2'b00;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_cnt_q        <= '0;
            r_grant_q      <= 2'b00;
            r_mem_req_q    <= 1'b0;
            r_mem_we_q     <= 1'b0;
            r_mem_addr_q   <= '0;
            r_mem_data_q   <= '0;
            r_mem_mask_q   <= '0;
            r_ibus_data_q  <= '0;
            r_ibus_ready_q <= 1'b0;
            r_dbus_data_q  <= '0;
            r_dbus_ready_q <= 1'b0;
            r_bus_err_q    <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_grant_q      <= w_grant_d;
            r_mem_req_q    <= w_mem_req_d;
            r_mem_we_q     <= w_mem_we_d;
            r_mem_addr_q   <= w_mem_addr_d;
            r_mem_data_q   <= w_mem_data_d;
            r_mem_mask_q   <= w_mem_mask_d;
            r_ibus_data_q  <= w_ibus_data_d;
            r_ibus_ready_q <= w_ibus_ready_d;
            r_dbus_data_q  <= w_dbus_data_d;
            r_dbus_ready_q <= w_dbus_ready_d;
            r_bus_err_q    <= w_bus_err_d;
        end
    end

    assign O_ibus_data  = r_ibus_data_q;
    assign O_ibus_ready = r_ibus_ready_q;
    assign O_dbus_data  = r_dbus_data_q;
    assign O_dbus_ready = r_dbus_ready_q;
    assign O_mem_req    = r_mem_req_q;
    assign O_mem_we     = r_mem_we_q;
    assign O_mem_addr   = r_mem_addr_q;
    assign O_mem_data   = r_mem_data_q;
    assign O_mem_mask   = r_mem_mask_q;
    assign O_bus_err    = r_bus_err_q;
    assign O_grant      = r_grant_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed bench for mem_bus_arbiter with a transaction-level
//               reference model checked every cycle plus literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int c_AW      = 32;
    localparam int c_DW      = 32;
    localparam int c_MW      = 4;
    localparam int c_TIMEOUT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            I_ibus_req, I_ibus_we;
    logic [c_AW-1:0] I_ibus_addr;
    logic [c_DW-1:0] I_ibus_data;
    logic [c_MW-1:0] I_ibus_mask;
    logic [c_DW-1:0] O_ibus_data;
    logic            O_ibus_ready;
    logic            I_dbus_req, I_dbus_we;
    logic [c_AW-1:0] I_dbus_addr;
    logic [c_DW-1:0] I_dbus_data;
    logic [c_MW-1:0] I_dbus_mask;
    logic [c_DW-1:0] O_dbus_data;
    logic            O_dbus_ready;
    logic            O_mem_req, O_mem_we;
    logic [c_AW-1:0] O_mem_addr;
    logic [c_DW-1:0] O_mem_data;
    logic [c_MW-1:0] O_mem_mask;
    logic [c_DW-1:0] I_mem_data;
    logic            I_mem_ready;
    logic            O_bus_err;
    logic [1:0]      O_grant;

    mem_bus_arbiter #(
        .ADDR_W (c_AW),
        .DATA_W (c_DW),
        .MASK_W (c_MW),
        .TIMEOUT(c_TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .I_ibus_req  (I_ibus_req),
        .I_ibus_we   (I_ibus_we),
        .I_ibus_addr (I_ibus_addr),
        .I_ibus_data (I_ibus_data),
        .I_ibus_mask (I_ibus_mask),
        .O_ibus_data (O_ibus_data),
        .O_ibus_ready(O_ibus_ready),
        .I_dbus_req  (I_dbus_req),
        .I_dbus_we   (I_dbus_we),
        .I_dbus_addr (I_dbus_addr),
        .I_dbus_data (I_dbus_data),
        .I_dbus_mask (I_dbus_mask),
        .O_dbus_data (O_dbus_data),
        .O_dbus_ready(O_dbus_ready),
        .O_mem_req   (O_mem_req),
        .O_mem_we    (O_mem_we),
        .O_mem_addr  (O_mem_addr),
        .O_mem_data  (O_mem_data),
        .O_mem_mask  (O_mem_mask),
        .I_mem_data  (I_mem_data),
        .I_mem_ready (I_mem_ready),
        .O_bus_err   (O_bus_err),
        .O_grant     (O_grant)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one outstanding transaction, tracked by phase flags.
    bit              m_busy, m_resp, m_last_d, m_own_d;
    int              m_wait;
    logic            e_mem_req, e_we, e_ir, e_dr, e_err;
    logic [1:0]      e_grant;
    logic [c_AW-1:0] e_addr;
    logic [c_DW-1:0] e_wdata, e_idata, e_ddata;
    logic [c_MW-1:0] e_mask;

    // Memory responder: answers on the mem_delay-th cycle of a request.
    int              mem_delay, issue_cnt;
    logic [c_DW-1:0] mem_rdata;
    bit              mem_force;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_last_d = 1; m_own_d = 0; m_wait = 0;
        e_mem_req = 0; e_we = 0; e_ir = 0; e_dr = 0; e_err = 0; e_grant = 2'b00;
        e_addr = '0; e_wdata = '0; e_idata = '0; e_ddata = '0; e_mask = '0;
    endtask

    task automatic model_step();
        bit              done, to;
        logic [c_DW-1:0] rd;
        done = 0; to = 0; rd = '0;
        if (rst) begin
            model_reset();
        end else if (m_resp) begin
            m_resp = 0; e_ir = 0; e_dr = 0; e_err = 0; e_grant = 2'b00;
        end else if (m_busy) begin
            m_wait++;
            if (I_mem_ready) begin
                done = 1; rd = I_mem_data;
            end else if (c_TIMEOUT != 0 && m_wait == c_TIMEOUT) begin
                done = 1; to = 1; rd = 32'hDEAD_BEEF;
            end
            if (done) begin
                m_busy = 0; m_resp = 1; e_mem_req = 0; e_err = to;
                if (m_own_d) begin e_dr = 1; e_ddata = rd; end
                else         begin e_ir = 1; e_idata = rd; end
            end
        end else if (I_ibus_req || I_dbus_req) begin
            if (I_ibus_req && I_dbus_req) begin
`ifdef ARB_RR_EN
                m_own_d = !m_last_d;
`else
                m_own_d = 1;
`endif
            end else begin
                m_own_d = I_dbus_req;
            end
            m_last_d  = m_own_d;
            m_busy    = 1;
            m_wait    = 0;
            e_mem_req = 1;
            e_grant   = m_own_d ? 2'b10 : 2'b01;
            e_we      = m_own_d ? I_dbus_we   : I_ibus_we;
            e_addr    = m_own_d ? I_dbus_addr : I_ibus_addr;
            e_wdata   = m_own_d ? I_dbus_data : I_ibus_data;
            e_mask    = m_own_d ? I_dbus_mask : I_ibus_mask;
        end
    endtask

    // Compare at the falling edge, advance the model, then move to just after
    // the next rising edge where the responder and the stimulus drive inputs.
    task automatic cycle();
        @(negedge clk);
        chk("mem_req",    O_mem_req,    e_mem_req);
        chk("grant",      O_grant,      e_grant);
        chk("ibus_ready", O_ibus_ready, e_ir);
        chk("dbus_ready", O_dbus_ready, e_dr);
        chk("bus_err",    O_bus_err,    e_err);
        chk("ibus_data",  O_ibus_data,  e_idata);
        chk("dbus_data",  O_dbus_data,  e_ddata);
        if (e_mem_req) begin
            chk("mem_we",    O_mem_we,   e_we);
            chk("mem_addr",  O_mem_addr, e_addr);
            chk("mem_wdata", O_mem_data, e_wdata);
            chk("mem_mask",  O_mem_mask, e_mask);
        end
        model_step();
        @(posedge clk);
        #1;
        if (mem_force) begin
            I_mem_ready = 1'b1; I_mem_data = mem_rdata;
        end else if (O_mem_req) begin
            issue_cnt++;
            I_mem_ready = (mem_delay != 0 && issue_cnt == mem_delay);
            I_mem_data  = I_mem_ready ? mem_rdata : 32'h5A5A_5A5A;
        end else begin
            issue_cnt = 0; I_mem_ready = 1'b0; I_mem_data = 32'h5A5A_5A5A;
        end
    endtask

    initial begin
        int         n_issue, n_pulse, n_got;
        logic [3:0] seq;
        rst = 1'b1;
        I_ibus_req = 0; I_ibus_we = 0; I_ibus_addr = '0; I_ibus_data = '0; I_ibus_mask = '0;
        I_dbus_req = 0; I_dbus_we = 0; I_dbus_addr = '0; I_dbus_data = '0; I_dbus_mask = '0;
        I_mem_data = 32'h5A5A_5A5A; I_mem_ready = 0;
        mem_delay = 0; issue_cnt = 0; mem_rdata = '0; mem_force = 0;
        seq = 4'b0000;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_mem_req", O_mem_req, 0);
        chk("rst_grant", O_grant, 0);
        chk("rst_ready", {O_ibus_ready, O_dbus_ready, O_bus_err}, 0);
        cycle();
        rst = 1'b0;
        cycle();

        // 1: ibus read answered in the first ISSUE cycle
        mem_delay = 1; mem_rdata = 32'h0000_0413;
        I_ibus_req = 1; I_ibus_we = 0; I_ibus_addr = 32'h8000_0000; I_ibus_mask = 4'hF;
        cycle();
        chk("t1_grant_issue", O_grant, 2'b01);
        chk("t1_mem_addr", O_mem_addr, 32'h8000_0000);
        cycle();
        chk("t1_ready", O_ibus_ready, 1);
        chk("t1_data", O_ibus_data, 32'h0000_0413);
        I_ibus_req = 0;
        cycle();
        chk("t1_ready_pulse_end", O_ibus_ready, 0);
        cycle();

        // 2: dbus write held for four ISSUE cycles
        mem_delay = 4; mem_rdata = 32'h1234_5678;
        I_dbus_req = 1; I_dbus_we = 1; I_dbus_addr = 32'h8000_0100;
        I_dbus_data = 32'hCAFE_BABE; I_dbus_mask = 4'h3;
        cycle();
        n_issue = 0; n_pulse = 0;
        for (int k = 0; k < 12; k++) begin
            if (O_mem_req) begin
                n_issue++;
                chk("t2_we", O_mem_we, 1);
                chk("t2_mask", O_mem_mask, 4'h3);
                chk("t2_wdata", O_mem_data, 32'hCAFE_BABE);
            end
            if (O_dbus_ready) begin
                n_pulse++; I_dbus_req = 0;
            end
            cycle();
        end
        chk("t2_issue_cycles", n_issue, 4);
        chk("t2_pulses", n_pulse, 1);

        // 3: both requesters held for four transactions after reset
        rst = 1; cycle(); rst = 0;
        mem_delay = 1; mem_rdata = 32'h0BAD_F00D;
        I_ibus_req = 1; I_ibus_we = 0; I_ibus_addr = 32'h8000_0010; I_ibus_mask = 4'hF;
        I_dbus_req = 1; I_dbus_we = 0; I_dbus_addr = 32'h8000_0200; I_dbus_mask = 4'hF;
        n_got = 0;
        for (int k = 0; k < 60 && n_got < 4; k++) begin
            cycle();
            if (O_ibus_ready || O_dbus_ready) begin
                seq[n_got] = O_dbus_ready;
                n_got++;
                if (n_got == 4) begin I_ibus_req = 0; I_dbus_req = 0; end
            end
        end
        chk("t3_count", n_got, 4);
`ifdef ARB_RR_EN
        chk("t3_seq_rr", seq, 4'b1010);
`else
        chk("t3_seq_fixed", seq, 4'b1111);
`endif
        cycle(); cycle();

        // 4: memory never answers, timeout after eight ISSUE cycles
        mem_delay = 0;
        I_dbus_req = 1; I_dbus_we = 0; I_dbus_addr = 32'h8000_0300;
        cycle();
        n_issue = 0;
        for (int k = 0; k < 40 && !O_dbus_ready; k++) begin
            if (O_mem_req) n_issue++;
            cycle();
        end
        chk("t4_issue_cycles", n_issue, 8);
        chk("t4_ready", O_dbus_ready, 1);
        chk("t4_data", O_dbus_data, 32'hDEAD_BEEF);
        chk("t4_err", O_bus_err, 1);
        chk("t4_ibus_ready", O_ibus_ready, 0);
        I_dbus_req = 0;
        cycle();
        chk("t4_err_clear", O_bus_err, 0);
        cycle();

        // 5: reset during ISSUE, then a stray memory ready
        I_ibus_req = 1; I_ibus_addr = 32'h8000_0400;
        cycle(); cycle(); cycle();
        chk("t5_in_issue", O_mem_req, 1);
        rst = 1; I_ibus_req = 0;
        cycle();
        chk("t5_mem_req_after_rst", O_mem_req, 0);
        chk("t5_no_ready_after_rst", O_ibus_ready, 0);
        rst = 0;
        mem_force = 1; mem_rdata = 32'h7777_0000;
        I_mem_ready = 1; I_mem_data = mem_rdata;
        n_pulse = 0;
        for (int k = 0; k < 6; k++) begin
            if (O_ibus_ready || O_dbus_ready || O_mem_req) n_pulse++;
            if (k == 2) mem_force = 0;
            cycle();
        end
        chk("t5_stray_events", n_pulse, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
